// File: rtl/ac_fan_driver.sv
// Fan/compressor actuator stage: slew-limited PWM fan drive plus anti-short-cycle compressor gating.
// Optional fan-stall supervision is compiled in with the AC_DRIVER_FAULT_EN macro.
module ac_fan_driver #(
   parameter int TICK_DIV      = 1000,
   parameter int RAMP_STEP     = 4,
   parameter int MIN_OFF_TICKS = 300,
   parameter int MIN_ON_TICKS  = 600,
   parameter int STALL_TICKS   = 50
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] fan_speed_i,
   input  logic [7:0] fan_heat_i,
   input  logic [6:0] outlet_temp_i,
   input  logic       fan_tach_i,
   output logic       fan_pwm_o,
   output logic [7:0] duty_now_o,
   output logic       comp_en_o,
   output logic       lockout_o,
   output logic       fault_o
);

   localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TIMER_MAX = (MIN_OFF_TICKS > MIN_ON_TICKS) ? MIN_OFF_TICKS : MIN_ON_TICKS;
   localparam int MW        = $clog2(TIMER_MAX + 1);

   typedef enum logic [1:0] {
      S_LOCKOUT = 2'd0,
      S_IDLE    = 2'd1,
      S_RUN_MIN = 2'd2,
      S_RUN     = 2'd3
   } compState_e;

   logic [TW-1:0] tickCnt_q, tickCnt_d;
   logic          tick;
   logic [7:0]    dutyNow_q, dutyNow_d;
   logic [7:0]    dutyTarget;
   logic [7:0]    dutyDiff;
   logic [7:0]    dutyStep;
   logic [7:0]    pwmCnt_q;
   logic          fanPwm_q, fanPwm_d;
   compState_e    state_q, state_d;
   logic [MW-1:0] timer_q, timer_d;
   logic          compEn_q, compEn_d;
   logic          lockout_q, lockout_d;
   logic          demand;
   logic          fanOff;
   logic          fault;

   assign tick   = (tickCnt_q == TW'(TICK_DIV - 1));
   assign fanOff = (fan_speed_i == 3'd0);
   assign demand = !fanOff && ({1'b0, outlet_temp_i} > fan_heat_i);

   always_comb begin
      tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
   end

   always_comb begin
      case (fan_speed_i)
         3'd0:    dutyTarget = 8'd0;
         3'd1:    dutyTarget = 8'd64;
         3'd2:    dutyTarget = 8'd128;
         3'd3:    dutyTarget = 8'd192;
         default: dutyTarget = 8'd255;
      endcase
   end

   // Step is clamped to the remaining distance so the ramp lands exactly on target.
   always_comb begin
      dutyNow_d = dutyNow_q;
      dutyDiff  = (dutyTarget > dutyNow_q) ? (dutyTarget - dutyNow_q) : (dutyNow_q - dutyTarget);
      dutyStep  = (dutyDiff > 8'(RAMP_STEP)) ? 8'(RAMP_STEP) : dutyDiff;
      if (tick) begin
         if (dutyTarget > dutyNow_q) begin
            dutyNow_d = dutyNow_q + dutyStep;
         end else begin
            dutyNow_d = dutyNow_q - dutyStep;
         end
      end
      if (fault) begin
         dutyNow_d = 8'd0;
      end
   end

   always_comb begin
      fanPwm_d = !fault && (pwmCnt_q < dutyNow_q);
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         S_LOCKOUT: begin
            if (tick) begin
               if (timer_q == MW'(MIN_OFF_TICKS - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  timer_d = timer_q + MW'(1);
               end
            end
         end
         S_IDLE: begin
            if (demand) begin
               state_d = S_RUN_MIN;
            end
         end
         S_RUN_MIN: begin
            if (fanOff) begin
               state_d = S_LOCKOUT;
            end else if (tick) begin
               if (timer_q == MW'(MIN_ON_TICKS - 1)) begin
                  state_d = S_RUN;
               end else begin
                  timer_d = timer_q + MW'(1);
               end
            end
         end
         S_RUN: begin
            if (!demand) begin
               state_d = S_LOCKOUT;
            end
         end
         default: state_d = S_LOCKOUT;
      endcase
      if (state_d != state_q) begin
         timer_d = '0;
      end
      // A stalled fan pins the FSM in lockout with the timer frozen.
      if (fault) begin
         state_d = S_LOCKOUT;
         timer_d = '0;
      end
      compEn_d  = (state_d == S_RUN_MIN) || (state_d == S_RUN);
      lockout_d = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tickCnt_q <= '0;
         dutyNow_q <= 8'd0;
         pwmCnt_q  <= 8'd0;
         fanPwm_q  <= 1'b0;
         state_q   <= S_LOCKOUT;
         timer_q   <= '0;
         compEn_q  <= 1'b0;
         lockout_q <= 1'b1;
      end else begin
         tickCnt_q <= tickCnt_d;
         dutyNow_q <= dutyNow_d;
         pwmCnt_q  <= pwmCnt_q + 8'd1;
         fanPwm_q  <= fanPwm_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         compEn_q  <= compEn_d;
         lockout_q <= lockout_d;
      end
   end

`ifdef AC_DRIVER_FAULT_EN
   localparam int SW = $clog2(STALL_TICKS + 1);

   logic [2:0]    tachSync_q;
   logic          tachRise;
   logic [SW-1:0] stallCnt_q, stallCnt_d;
   logic          fault_q, fault_d;

   assign tachRise = tachSync_q[1] && !tachSync_q[2];
   assign fault    = fault_q;

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (tachRise || (dutyNow_q < 8'd64)) begin
         stallCnt_d = '0;
      end else if (tick && (stallCnt_q != SW'(STALL_TICKS))) begin
         stallCnt_d = stallCnt_q + SW'(1);
      end
      fault_d = fault_q || (stallCnt_q == SW'(STALL_TICKS));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tachSync_q <= 3'b000;
         stallCnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         tachSync_q <= {tachSync_q[1:0], fan_tach_i};
         stallCnt_q <= stallCnt_d;
         fault_q    <= fault_d;
      end
   end
`else
   logic unusedTach;

   assign unusedTach = fan_tach_i;
   assign fault      = 1'b0;
`endif

   assign fan_pwm_o  = fanPwm_q;
   assign duty_now_o = dutyNow_q;
   assign comp_en_o  = compEn_q;
   assign lockout_o  = lockout_q;
   assign fault_o    = fault;

endmodule

// File: tb/tb_ac_fan_driver.sv
// Directed bench for ac_fan_driver with a short timebase (TICK_DIV=4).
// The stall-fault section is included only when AC_DRIVER_FAULT_EN is defined.
module tb_ac_fan_driver;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [2:0] fanSpeed = 3'd0;
   logic [7:0] fanHeat = 8'd0;
   logic [6:0] outletTemp = 7'd0;
   logic       fanTach = 1'b0;
   logic       tachEn = 1'b1;
   logic       fanPwm;
   logic [7:0] dutyNow;
   logic       compEn;
   logic       lockout;
   logic       fault;

   int testCnt = 0;
   int failCnt = 0;
   int cyc;

   ac_fan_driver #(
      .TICK_DIV(TICK_DIV),
      .RAMP_STEP(16),
      .MIN_OFF_TICKS(3),
      .MIN_ON_TICKS(5),
      .STALL_TICKS(8)
   ) dut (
      .clk_i(clk),
      .rst_ni(rstN),
      .fan_speed_i(fanSpeed),
      .fan_heat_i(fanHeat),
      .outlet_temp_i(outletTemp),
      .fan_tach_i(fanTach),
      .fan_pwm_o(fanPwm),
      .duty_now_o(dutyNow),
      .comp_en_o(compEn),
      .lockout_o(lockout),
      .fault_o(fault)
   );

   always #5 clk = ~clk;

   always #20 if (tachEn) fanTach = ~fanTach;

   // Bench-side count of clock edges since reset release; tick edges are multiples of TICK_DIV.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic stepClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) begin
         stepClk(1);
         while (cyc % TICK_DIV != 0) stepClk(1);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] speed, input logic [7:0] heat, input logic [6:0] outlet);
      fanSpeed   = speed;
      fanHeat    = heat;
      outletTemp = outlet;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp)
      else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic countPwmHigh(output int hi);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         stepClk(1);
         if (fanPwm === 1'b1) hi++;
      end
   endtask

   // Assumes reset was just released at a falling edge with demand present.
   task automatic checkLockoutServed(input string tag);
      stepClk(11);
      checkOutput({tag, "_comp_clk11"}, compEn, 0);
      checkOutput({tag, "_lock_clk11"}, lockout, 1);
      stepClk(1);
      checkOutput({tag, "_comp_clk12"}, compEn, 0);
      checkOutput({tag, "_lock_clk12"}, lockout, 0);
      stepClk(1);
      checkOutput({tag, "_comp_clk13"}, compEn, 1);
   endtask

   initial begin
      int hi;
      applyStimulus(3'd4, 8'd20, 7'd25);
      stepClk(3);
      checkOutput("rst_pwm", fanPwm, 0);
      checkOutput("rst_duty", dutyNow, 0);
      checkOutput("rst_comp", compEn, 0);
      checkOutput("rst_lock", lockout, 1);
      checkOutput("rst_fault", fault, 0);
      rstN = 1'b1;

      checkLockoutServed("lock1");
      checkOutput("ramp_up_48", dutyNow, 48);
      waitTicks(12);
      checkOutput("ramp_up_240", dutyNow, 240);
      waitTicks(1);
      checkOutput("ramp_up_255", dutyNow, 255);
      waitTicks(1);
      checkOutput("ramp_hold_255", dutyNow, 255);
      checkOutput("run_comp", compEn, 1);

      applyStimulus(3'd1, 8'd20, 7'd25);
      waitTicks(1);
      checkOutput("ramp_dn_239", dutyNow, 239);
      waitTicks(10);
      checkOutput("ramp_dn_79", dutyNow, 79);
      waitTicks(1);
      checkOutput("ramp_dn_64", dutyNow, 64);
      waitTicks(1);
      checkOutput("ramp_hold_64", dutyNow, 64);

      countPwmHigh(hi);
      checkOutput("pwm_duty64", hi, 64);

      waitTicks(1);
      applyStimulus(3'd2, 8'd20, 7'd18);
      stepClk(1);
      checkOutput("run_nodemand_comp", compEn, 0);
      checkOutput("run_nodemand_lock", lockout, 1);
      applyStimulus(3'd2, 8'd20, 7'd25);
      waitTicks(2);
      checkOutput("minoff_comp_t2", compEn, 0);
      checkOutput("minoff_lock_t2", lockout, 1);
      waitTicks(1);
      checkOutput("minoff_comp_t3", compEn, 0);
      checkOutput("minoff_lock_t3", lockout, 0);
      stepClk(1);
      checkOutput("runmin_comp_on", compEn, 1);
      waitTicks(1);
      applyStimulus(3'd2, 8'd20, 7'd18);
      waitTicks(3);
      checkOutput("minon_comp_t4", compEn, 1);
      waitTicks(1);
      checkOutput("minon_comp_t5", compEn, 1);
      checkOutput("minon_lock_t5", lockout, 0);
      stepClk(1);
      checkOutput("minon_done_comp", compEn, 0);
      checkOutput("minon_done_lock", lockout, 1);

      applyStimulus(3'd2, 8'd20, 7'd20);
      waitTicks(3);
      stepClk(1);
      checkOutput("equal_nodemand_comp", compEn, 0);
      applyStimulus(3'd2, 8'd20, 7'd25);
      stepClk(1);
      checkOutput("relock_comp_on", compEn, 1);
      waitTicks(2);
      applyStimulus(3'd0, 8'd20, 7'd25);
      stepClk(1);
      checkOutput("fanoff_comp", compEn, 0);
      checkOutput("fanoff_lock", lockout, 1);
      waitTicks(1);
      checkOutput("ramp_dn_112", dutyNow, 112);
      waitTicks(7);
      checkOutput("ramp_dn_0", dutyNow, 0);
      stepClk(2);
      countPwmHigh(hi);
      checkOutput("pwm_duty0", hi, 0);
      checkOutput("fanoff_comp_idle", compEn, 0);

      applyStimulus(3'd4, 8'd20, 7'd25);
      waitTicks(3);
      checkOutput("pre_reset_duty", dutyNow, 48);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("midrst_duty", dutyNow, 0);
      checkOutput("midrst_comp", compEn, 0);
      checkOutput("midrst_lock", lockout, 1);
      @(negedge clk);
      rstN = 1'b1;
      checkLockoutServed("lock2");

`ifdef AC_DRIVER_FAULT_EN
      applyStimulus(3'd2, 8'd20, 7'd25);
      waitTicks(4);
      checkOutput("tach_ok_fault", fault, 0);
      tachEn = 1'b0;
      waitTicks(16);
      checkOutput("stall_fault", fault, 1);
      checkOutput("stall_duty", dutyNow, 0);
      checkOutput("stall_comp", compEn, 0);
      checkOutput("stall_pwm", fanPwm, 0);
      checkOutput("stall_lock", lockout, 1);
      tachEn = 1'b1;
      waitTicks(6);
      checkOutput("stall_latched", fault, 1);
      checkOutput("stall_latched_comp", compEn, 0);
      rstN = 1'b0;
      stepClk(1);
      checkOutput("stall_rst_clear", fault, 0);
      rstN = 1'b1;
      stepClk(2);
`endif

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
